// File: rtl/rps_pkg.sv
// -----------------------------------------------------------------------------
// rps_pkg
// Shared definitions for the rock-paper-scissors match controller.
//   - move codes   : 2-bit player move encoding
//   - result codes : 2-bit round outcome encoding
//   - state_t      : match controller FSM states
// -----------------------------------------------------------------------------
package rps_pkg;

  // Player move encoding
  localparam logic [1:0] MOVE_STONE    = 2'b00;
  localparam logic [1:0] MOVE_PAPER    = 2'b01;
  localparam logic [1:0] MOVE_SCISSORS = 2'b10;
  localparam logic [1:0] MOVE_INVALID  = 2'b11;

  // Round outcome encoding
  localparam logic [1:0] RES_TIE  = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_VOID = 2'b11;

  // Match winner encoding (shares the P1/P2 codes with round results)
  localparam logic [1:0] WINNER_NONE = 2'b00;

  // Width of the COLLECT timeout counter
  localparam int TIMER_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_JUDGE   = 3'd2,
    ST_REPORT  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/rps_judge.sv
// -----------------------------------------------------------------------------
// rps_judge
// Pure combinational referee for one round.
// Ports:
//   p1_move  in  2  move of player 1
//   p2_move  in  2  move of player 2
//   result   out 2  RES_TIE / RES_P1 / RES_P2 / RES_VOID
// An invalid move loses to any valid move; two invalid moves void the round.
// -----------------------------------------------------------------------------
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  output logic [1:0] result
);

  always_comb begin
    result = RES_TIE;
    if (p1_move == MOVE_INVALID && p2_move == MOVE_INVALID) begin
      result = RES_VOID;
    end else if (p1_move == MOVE_INVALID) begin
      result = RES_P2;
    end else if (p2_move == MOVE_INVALID) begin
      result = RES_P1;
    end else if (p1_move == p2_move) begin
      result = RES_TIE;
    end else begin
      case ({p1_move, p2_move})
        {MOVE_STONE,    MOVE_SCISSORS},
        {MOVE_SCISSORS, MOVE_PAPER},
        {MOVE_PAPER,    MOVE_STONE}:    result = RES_P1;
        default:                        result = RES_P2;
      endcase
    end
  end

endmodule

// File: rtl/rps_match_controller.sv
// -----------------------------------------------------------------------------
// rps_match_controller
// Runs a first-to-WIN_TARGET rock-paper-scissors match between two players.
// Parameters:
//   WIN_TARGET      round wins needed to take the match (1..15)
//   TIMEOUT_CYCLES  COLLECT cycles allowed before a forfeit (1..255)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             match control pulses
//   p1_move/valid/ready      P1 move handshake (p2_* likewise for P2)
//   round_result, round_done last round outcome and its one-cycle strobe
//   p1_score, p2_score       round wins in the current match
//   match_done, match_winner match finished flag and winner
//   busy                     high while a match is in progress
// All outputs are registered.
// -----------------------------------------------------------------------------
module rps_match_controller
  import rps_pkg::*;
#(
  parameter int WIN_TARGET     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] p1_move,
  input  logic       p1_valid,
  output logic       p1_ready,
  input  logic [1:0] p2_move,
  input  logic       p2_valid,
  output logic       p2_ready,
  output logic [1:0] round_result,
  output logic       round_done,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic       busy
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]         SCORE_TARGET  = 4'(WIN_TARGET);

  state_t              state_reg;
  logic [1:0]          p1_move_reg, p2_move_reg;
  logic                p1_cap_reg, p2_cap_reg;
  logic                timed_out_reg;
  logic [TIMER_W-1:0]  timer_reg;
  logic                p1_ready_reg, p2_ready_reg;
  logic [1:0]          round_result_reg;
  logic                round_done_reg;
  logic [3:0]          p1_score_reg, p2_score_reg;
  logic                match_done_reg;
  logic [1:0]          match_winner_reg;
  logic                busy_reg;

  // Handshakes completing at this edge
  logic p1_take, p2_take;
  logic p1_cap_next, p2_cap_next;
  logic timer_expired;
  logic [1:0] judge_result;
  logic [1:0] round_result_next;

  assign p1_take     = (state_reg == ST_COLLECT) && p1_valid && p1_ready_reg;
  assign p2_take     = (state_reg == ST_COLLECT) && p2_valid && p2_ready_reg;
  assign p1_cap_next = p1_cap_reg | p1_take;
  assign p2_cap_next = p2_cap_reg | p2_take;

  // The counter holds the number of completed COLLECT cycles; it reaches the
  // limit at the edge that closes the last allowed cycle.
  assign timer_expired = (timer_reg + TIMER_W'(1)) == TIMEOUT_LIMIT;

  rps_judge u_judge (
    .p1_move (p1_move_reg),
    .p2_move (p2_move_reg),
    .result  (judge_result)
  );

  // Forfeits do not consult the referee: the present player wins outright,
  // and a round where nobody moved is void.
  always_comb begin
    round_result_next = judge_result;
    if (timed_out_reg) begin
      case ({p1_cap_reg, p2_cap_reg})
        2'b10:   round_result_next = RES_P1;
        2'b01:   round_result_next = RES_P2;
        default: round_result_next = RES_VOID;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      p1_move_reg      <= MOVE_STONE;
      p2_move_reg      <= MOVE_STONE;
      p1_cap_reg       <= 1'b0;
      p2_cap_reg       <= 1'b0;
      timed_out_reg    <= 1'b0;
      timer_reg        <= '0;
      p1_ready_reg     <= 1'b0;
      p2_ready_reg     <= 1'b0;
      round_result_reg <= RES_TIE;
      round_done_reg   <= 1'b0;
      p1_score_reg     <= '0;
      p2_score_reg     <= '0;
      match_done_reg   <= 1'b0;
      match_winner_reg <= WINNER_NONE;
      busy_reg         <= 1'b0;
    end else begin
      round_done_reg <= 1'b0;

      if (busy_reg && abort) begin
        // Abandon the match: captured moves are dropped, scores are kept
        state_reg        <= ST_IDLE;
        p1_cap_reg       <= 1'b0;
        p2_cap_reg       <= 1'b0;
        timed_out_reg    <= 1'b0;
        timer_reg        <= '0;
        p1_ready_reg     <= 1'b0;
        p2_ready_reg     <= 1'b0;
        match_winner_reg <= WINNER_NONE;
        busy_reg         <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            // abort alongside start suppresses the start
            if (start && !abort) begin
              p1_score_reg     <= '0;
              p2_score_reg     <= '0;
              match_winner_reg <= WINNER_NONE;
              round_result_reg <= RES_TIE;
              match_done_reg   <= 1'b0;
              busy_reg         <= 1'b1;
              state_reg        <= ST_COLLECT;
              timer_reg        <= '0;
              p1_cap_reg       <= 1'b0;
              p2_cap_reg       <= 1'b0;
              timed_out_reg    <= 1'b0;
              p1_ready_reg     <= 1'b1;
              p2_ready_reg     <= 1'b1;
            end
          end

          ST_COLLECT: begin
            if (p1_take) begin
              p1_move_reg <= p1_move;
              p1_cap_reg  <= 1'b1;
            end
            if (p2_take) begin
              p2_move_reg <= p2_move;
              p2_cap_reg  <= 1'b1;
            end
            timer_reg <= timer_reg + TIMER_W'(1);

            // A capture on the expiry cycle is counted before the timeout
            // is considered, so a late second move still gets judged.
            if (p1_cap_next && p2_cap_next) begin
              state_reg     <= ST_JUDGE;
              timed_out_reg <= 1'b0;
              p1_ready_reg  <= 1'b0;
              p2_ready_reg  <= 1'b0;
            end else if (timer_expired) begin
              state_reg     <= ST_JUDGE;
              timed_out_reg <= 1'b1;
              p1_ready_reg  <= 1'b0;
              p2_ready_reg  <= 1'b0;
            end else begin
              p1_ready_reg <= p1_ready_reg & ~p1_take;
              p2_ready_reg <= p2_ready_reg & ~p2_take;
            end
          end

          ST_JUDGE: begin
            round_result_reg <= round_result_next;
            round_done_reg   <= 1'b1;
            if (round_result_next == RES_P1 && p1_score_reg < SCORE_TARGET) begin
              p1_score_reg <= p1_score_reg + 4'd1;
            end
            if (round_result_next == RES_P2 && p2_score_reg < SCORE_TARGET) begin
              p2_score_reg <= p2_score_reg + 4'd1;
            end
            state_reg <= ST_REPORT;
          end

          ST_REPORT: begin
            if (p1_score_reg == SCORE_TARGET || p2_score_reg == SCORE_TARGET) begin
              state_reg        <= ST_DONE;
              match_done_reg   <= 1'b1;
              busy_reg         <= 1'b0;
              match_winner_reg <= (p1_score_reg == SCORE_TARGET) ? RES_P1 : RES_P2;
            end else begin
              state_reg     <= ST_COLLECT;
              timer_reg     <= '0;
              p1_cap_reg    <= 1'b0;
              p2_cap_reg    <= 1'b0;
              timed_out_reg <= 1'b0;
              p1_ready_reg  <= 1'b1;
              p2_ready_reg  <= 1'b1;
            end
          end

          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign p1_ready     = p1_ready_reg;
  assign p2_ready     = p2_ready_reg;
  assign round_result = round_result_reg;
  assign round_done   = round_done_reg;
  assign p1_score     = p1_score_reg;
  assign p2_score     = p2_score_reg;
  assign match_done   = match_done_reg;
  assign match_winner = match_winner_reg;
  assign busy         = busy_reg;

endmodule
